// File: rtl/audio_seq_pkg.sv
// Shared state encoding and default geometry for the audio record/playback sequencer.
// Defaults describe a 5 s, 8-bit, 8 kHz sample buffer behind a read-latency-2 BRAM.
package audio_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;

  localparam int DEF_BRAM_DEPTH   = 40000;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_READ_LATENCY = 2;

endpackage

// File: rtl/seq_valid_pipe.sv
// Shift register tracking in-flight BRAM reads; the last stage marks douta_in as valid.
// Latency STAGES cycles from issue_in to out_vld, no backpressure; STAGES must be >= 2.
module seq_valid_pipe #(
  parameter int STAGES = 3
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic issue_in,
  output logic out_vld,
  output logic empty_out
);

  logic [STAGES-1:0] pipe_q;
  logic [STAGES-1:0] pipe_d;

  always_comb begin
    pipe_d = {pipe_q[STAGES-2:0], issue_in};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out_vld   = pipe_q[STAGES-1];
  assign empty_out = ~|pipe_q;

endmodule

// File: rtl/audio_bram_seq.sv
// Record/playback sequencer owning the sample BRAM pointers and recorded length.
// Writes land one cycle after sample_valid_in; playback strobes READ_LATENCY+2 cycles after tick_in. AUDIO_SEQ_LOOP_EN selects looped playback.
module audio_bram_seq
  import audio_seq_pkg::*;
#(
  parameter int BRAM_DEPTH   = DEF_BRAM_DEPTH,
  parameter int ADDR_WIDTH   = $clog2(BRAM_DEPTH),
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  record_in,
  input  logic                  play_in,
  input  logic                  stop_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic                  tick_in,
  output logic [ADDR_WIDTH-1:0] addra_out,
  input  logic [DATA_WIDTH-1:0] douta_in,
  output logic [ADDR_WIDTH-1:0] addrb_out,
  output logic [DATA_WIDTH-1:0] dinb_out,
  output logic                  web_out,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid_out,
  output logic [ADDR_WIDTH:0]   length_out,
  output logic [1:0]            state_out,
  output logic                  busy_out
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(BRAM_DEPTH);

  seq_state_t state_q, state_d;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         length_q, length_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] addrb_q, addrb_d;
  logic [DATA_WIDTH-1:0] dinb_q, dinb_d;
  logic [ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  sample_vld_q, sample_vld_d;

  logic wr_fire;
  logic rd_fire;
  logic wr_full;
  logic last_rd;
  logic pipe_out_vld;
  logic pipe_empty;

  // stop_in wins over a same-cycle sample or tick, so the event is simply dropped
  assign wr_fire = (state_q == RECORD) && sample_valid_in && !stop_in;
  assign rd_fire = (state_q == PLAY) && tick_in && !stop_in;
  assign wr_full = (wr_ptr_q + PW'(1)) == DEPTH_P;
  assign last_rd = rd_ptr_q == (length_q - PW'(1));

  seq_valid_pipe #(
    .STAGES(READ_LATENCY + 1)
  ) u_valid_pipe (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .issue_in (rd_fire),
    .out_vld  (pipe_out_vld),
    .empty_out(pipe_empty)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (record_in) begin
          state_d = RECORD;
        end else if (play_in && (length_q != '0)) begin
          state_d = PLAY;
        end
      end
      RECORD: begin
        if (stop_in || (wr_fire && wr_full)) begin
          state_d = IDLE;
        end
      end
      PLAY: begin
        if (stop_in) begin
          state_d = DRAIN;
        end
`ifndef AUDIO_SEQ_LOOP_EN
        else if (rd_fire && last_rd) begin
          state_d = DRAIN;
        end
`endif
      end
      DRAIN: begin
        if (pipe_empty) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    length_d     = length_q;
    web_d        = 1'b0;
    addrb_d      = addrb_q;
    dinb_d       = dinb_q;
    addra_d      = addra_q;
    sample_d     = sample_q;
    sample_vld_d = pipe_out_vld;

    if (state_q == IDLE) begin
      if (record_in) begin
        wr_ptr_d = '0;
        length_d = '0;
      end else if (play_in && (length_q != '0)) begin
        rd_ptr_d = '0;
      end
    end

    if (state_q == RECORD && stop_in) begin
      length_d = wr_ptr_q;
    end

    if (wr_fire) begin
      web_d    = 1'b1;
      addrb_d  = wr_ptr_q[ADDR_WIDTH-1:0];
      dinb_d   = sample_in;
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (wr_full) begin
        length_d = DEPTH_P;
      end
    end

    if (rd_fire) begin
      addra_d = rd_ptr_q[ADDR_WIDTH-1:0];
`ifdef AUDIO_SEQ_LOOP_EN
      rd_ptr_d = last_rd ? '0 : rd_ptr_q + PW'(1);
`else
      rd_ptr_d = rd_ptr_q + PW'(1);
`endif
    end

    if (pipe_out_vld) begin
      sample_d = douta_in;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      length_q     <= '0;
      web_q        <= 1'b0;
      addrb_q      <= '0;
      dinb_q       <= '0;
      addra_q      <= '0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      length_q     <= length_d;
      web_q        <= web_d;
      addrb_q      <= addrb_d;
      dinb_q       <= dinb_d;
      addra_q      <= addra_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
    end
  end

  always_comb begin
    state_out = state_q;
    busy_out  = (state_q != IDLE);
  end

  assign addra_out        = addra_q;
  assign addrb_out        = addrb_q;
  assign dinb_out         = dinb_q;
  assign web_out          = web_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = sample_vld_q;
  assign length_out       = length_q;

endmodule

// File: tb/tb_audio_bram_seq.sv
// Bench for audio_bram_seq with an 8-deep read-first BRAM model (read latency 2).
// Vector table for recording/command handling, scoreboard queue for playback strobes.
module tb_audio_bram_seq;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       record_in = 1'b0, play_in = 1'b0, stop_in = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       sample_valid_in = 1'b0;
  logic       tick_in = 1'b0;
  logic [2:0] addra_out, addrb_out;
  logic [7:0] douta_in, dinb_out, sample_out;
  logic       web_out, sample_valid_out, busy_out;
  logic [3:0] length_out;
  logic [1:0] state_out;

  audio_bram_seq #(.BRAM_DEPTH(8)) dut (
    .clk_in(clk), .rst_in(rst_in), .record_in(record_in), .play_in(play_in),
    .stop_in(stop_in), .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .tick_in(tick_in), .addra_out(addra_out), .douta_in(douta_in),
    .addrb_out(addrb_out), .dinb_out(dinb_out), .web_out(web_out),
    .sample_out(sample_out), .sample_valid_out(sample_valid_out),
    .length_out(length_out), .state_out(state_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  // BRAM model: port B write, port A two-stage registered read
  logic [7:0] mem [8];
  logic [7:0] rd1 = 8'h00;
  initial douta_in = 8'h00;
  always @(posedge clk) begin
    if (web_out) mem[addrb_out] <= dinb_out;
    rd1      <= mem[addra_out];
    douta_in <= rd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] dat; int cyc; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int n_vec = 0, n_err = 0, n_strobe = 0, n_web = 0;

  always @(negedge clk) begin
    if (web_out) n_web++;
    if (!rst_in && sample_valid_out) begin
      n_strobe++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got data %0h at cycle %0d, required no strobe", sample_out, cyc);
      end else begin
        e = exp_q.pop_front();
        if (sample_out !== e.dat || cyc != e.cyc) begin
          n_err++;
          $display("FAIL strobe: got %0h at cycle %0d, required %0h at cycle %0d", sample_out, cyc, e.dat, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic do_tick(input logic [7:0] d);
    exp_t t;
    t.dat = d;
    t.cyc = cyc + 4;
    exp_q.push_back(t);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
  endtask

  task automatic pulse_play();
    play_in = 1'b1;
    step();
    play_in = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((state_out != 2'd0 || exp_q.size() != 0) && k < 40) begin
      step();
      k++;
    end
    chk({nm, "_idle"}, state_out, 0);
    chk({nm, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  typedef struct {
    logic       rec, play, stop, sv;
    logic [7:0] smp;
    logic [1:0] st;
    logic       web;
    logic [2:0] addrb;
    logic [7:0] dinb;
    logic [3:0] len;
  } vec_t;
  vec_t tbl[10];

  logic [7:0] base;
  int s0, w0;

  initial begin
    // play with no recording, record+play priority, writes, ignored play, stop dropping a sample
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd0, 8'h00, 4'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 3'd0, 8'h00, 4'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 2'd1, 1'b1, 3'd0, 8'h10, 4'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'd1, 1'b1, 3'd1, 8'h11, 4'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 3'd0, 8'h00, 4'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 2'd1, 1'b1, 3'd2, 8'h12, 4'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h13, 2'd1, 1'b1, 3'd3, 8'h13, 4'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h14, 2'd1, 1'b1, 3'd4, 8'h14, 4'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h99, 2'd0, 1'b0, 3'd0, 8'h00, 4'd5};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 3'd0, 8'h00, 4'd5};

    repeat (3) step();
    rst_in = 1'b0;
    step();
    chk("rst_state", state_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_web", web_out, 0);
    chk("rst_len", length_out, 0);
    chk("rst_sample", sample_out, 0);
    chk("rst_addra", addra_out, 0);

    for (int i = 0; i < 10; i++) begin
      record_in       = tbl[i].rec;
      play_in         = tbl[i].play;
      stop_in         = tbl[i].stop;
      sample_valid_in = tbl[i].sv;
      sample_in       = tbl[i].smp;
      step();
      chk($sformatf("vec%0d_state", i), state_out, tbl[i].st);
      chk($sformatf("vec%0d_web", i), web_out, tbl[i].web);
      chk($sformatf("vec%0d_len", i), length_out, tbl[i].len);
      if (tbl[i].web) begin
        chk($sformatf("vec%0d_addrb", i), addrb_out, tbl[i].addrb);
        chk($sformatf("vec%0d_dinb", i), dinb_out, tbl[i].dinb);
      end
    end
    record_in = 1'b0; play_in = 1'b0; stop_in = 1'b0; sample_valid_in = 1'b0;
    base = 8'h10;

`ifndef AUDIO_SEQ_LOOP_EN
    // single-shot playback of all five samples, with a stray sample during PLAY
    pulse_play();
    chk("play_state", state_out, 2);
    chk("play_busy", busy_out, 1);
    for (int i = 0; i < 5; i++) begin
      sample_valid_in = (i == 1);
      do_tick(base + 8'(i));
      sample_valid_in = 1'b0;
      if (i == 1) chk("play_no_write", web_out, 0);
      repeat (1 + (i % 2)) step();
    end
    chk("play_last_drain", state_out, 3);
    wait_idle("play");
`endif

    // stop one cycle after the second tick
    s0 = n_strobe;
    pulse_play();
    do_tick(base);
    step();
    do_tick(base + 8'd1);
    pulse_stop();
    chk("stop_drain", state_out, 3);
    wait_idle("stop");
    chk("stop_strobes", n_strobe - s0, 2);

    // stop coincident with a tick drops that tick
    s0 = n_strobe;
    pulse_play();
    do_tick(base);
    tick_in = 1'b1;
    stop_in = 1'b1;
    step();
    tick_in = 1'b0;
    stop_in = 1'b0;
    chk("stoptick_drain", state_out, 3);
    wait_idle("stoptick");
    chk("stoptick_strobes", n_strobe - s0, 1);

    // back-to-back ticks give back-to-back strobes
    s0 = n_strobe;
    pulse_play();
    do_tick(base);
    do_tick(base + 8'd1);
    do_tick(base + 8'd2);
    chk("b2b_still_play", state_out, 2);
    pulse_stop();
    wait_idle("b2b");
    chk("b2b_strobes", n_strobe - s0, 3);

`ifdef AUDIO_SEQ_LOOP_EN
    record_in = 1'b1;
    step();
    record_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_valid_in = 1'b1;
      sample_in = 8'hA0 + 8'(i);
      step();
    end
    sample_valid_in = 1'b0;
    pulse_stop();
    chk("loop_len", length_out, 3);
    pulse_play();
    for (int i = 0; i < 7; i++) begin
      do_tick(8'hA0 + 8'(i % 3));
      step();
    end
    repeat (6) step();
    chk("loop_still_play", state_out, 2);
    chk("loop_pending", exp_q.size(), 0);
    pulse_stop();
    wait_idle("loop");
`endif

    // full buffer, entered with record and play together while a recording exists
    w0 = n_web;
    record_in = 1'b1;
    play_in = 1'b1;
    step();
    record_in = 1'b0;
    play_in = 1'b0;
    chk("full_rec_prio", state_out, 1);
    chk("full_len_clear", length_out, 0);
    for (int i = 0; i < 10; i++) begin
      sample_valid_in = 1'b1;
      sample_in = 8'h20 + 8'(i);
      step();
      if (i == 7) begin
        chk("full_idle", state_out, 0);
        chk("full_len", length_out, 8);
      end
      if (i >= 8) chk($sformatf("full_no_write%0d", i), web_out, 0);
    end
    sample_valid_in = 1'b0;
    step();
    chk("full_writes", n_web - w0, 8);
    base = 8'h20;

    // async reset between edges in the middle of playback
    pulse_play();
    do_tick(base);
    repeat (6) step();
    chk("arst_pre_sample", sample_out, base);
    do_tick(base + 8'd1);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_sample", sample_out, 0);
    chk("arst_len", length_out, 0);
    chk("arst_state", state_out, 0);
    chk("arst_busy", busy_out, 0);
    chk("arst_addra", addra_out, 0);
    exp_q.delete();
    step();
    rst_in = 1'b0;
    pulse_play();
    chk("arst_play_ignored", state_out, 0);
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
